lifo_stack_param: RTL and testbench
===================================

// Module: lifo_stack_param
// PURPOSE
//  Parametrised LIFO stack: successor to the fixed 16x32 stack used by the CPU datapath for CALL/RET and PUSH/POP.
//  Configurable width and depth, separate push/pop strobes and simultaneous push+pop (replace-top).
//  Exposes full/empty/count and sticky overflow/underflow error flags to the control unit.
// PARAMETERS
//  WIDTH  16  data word width in bits
//  DEPTH  32  number of slots; power of two, >= 2
//  AW     $clog2(DEPTH)  pointer width (derived, do not override)
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        asynchronous, active-low reset
//  en         in   1        cycle enable; 0 = hold all state, ignore push/pop/clr
//  clr        in   1        synchronous soft clear (qualified by en)
//  push       in   1        write din onto top of stack
//  pop        in   1        remove top of stack, present it on dout
//  din        in   WIDTH    push data
//  dout       out  WIDTH    last popped word (registered)
//  dout_vld   out  1        1-cycle pulse: dout updated this cycle
//  empty      out  1        count == 0
//  full       out  1        count == DEPTH
//  count      out  AW+1     slots in use, 0..DEPTH
//  ovf        out  1        sticky: push attempted while full (without pop)
//  udf        out  1        sticky: pop attempted while empty
//  top        out  WIDTH    [LIFO_PEEK_EN only] current top-of-stack word
// BEHAVIOUR
//  - Reset (rst=0, async): count=0, dout=0, dout_vld=0, ovf=0, udf=0; empty=1, full=0. Memory contents not reset.
//  - Reset mid-operation aborts any push/pop in flight; stack is empty on first edge after release.
//  - Storage: mem[0..DEPTH-1]; sp == count points to next free slot; top word at mem[sp-1].
//  - All updates on posedge clk when en=1. en=0: no state change, dout_vld=0.
//  - Priority per cycle (en=1): clr > push/pop.
//  - clr: count=0, ovf=0, udf=0, dout_vld=0; dout holds last value.
//  - push only, !full: mem[sp]<=din; count+1.
//  - push only, full: dropped, count unchanged, ovf<=1.
//  - pop only, !empty: dout<=mem[sp-1]; dout_vld=1; count-1. Latency: dout valid the edge after the pop cycle.
//  - pop only, empty: dout unchanged, dout_vld=0, udf<=1.
//  - push+pop, !empty (incl. full): replace-top: dout<=old mem[sp-1], mem[sp-1]<=din, dout_vld=1, count unchanged; no ovf.
//  - push+pop, empty: treated as push only (count 0->1); udf<=1; dout_vld=0.
//  - empty/full are combinational decodes of registered count; count never wraps (saturates at 0 and DEPTH).
//  - ovf/udf sticky until rst or clr; error events never change count.
// CONFIGURATION
//  LIFO_PEEK_EN defined: top port present; top = mem[count-1] when !empty, 0 when empty; combinational from registered state,
//    reflects the new top the cycle after each push/pop/replace.
//  LIFO_PEEK_EN undefined: top port absent; no read mux on count-1 beyond the pop path.
// TESTING
//  1. rst=0 async mid-cycle after 3 pushes -> count=0, empty=1, dout=0, ovf=udf=0 immediately, no clock edge needed.
//  2. WIDTH=16,DEPTH=4: push 0x1111,0x2222,0x3333,0x4444 -> full=1,count=4; 5th push 0x5555 -> ovf=1, count=4;
//     4 pops -> dout 0x4444,0x3333,0x2222,0x1111 each with dout_vld pulse, then empty=1.
//  3. From empty: pop -> udf=1, dout_vld=0, count=0; push+pop with din=0xABCD -> count=1, top=0xABCD (peek build).
//  4. Stack [0x0001,0x0002]: push+pop din=0x00FF -> dout=0x0002, dout_vld=1, count=2; pop -> dout=0x00FF.
//  5. en=0 with push=pop=clr=1 for 5 cycles -> count, dout, flags unchanged, dout_vld=0.
//  6. With ovf=udf=1 and count=3: clr -> count=0, ovf=udf=0, dout unchanged; push/pop held same cycle are ignored.

Source files
------------

// File: rtl/lifo_stack_param.sv
// Parametrised LIFO stack with push/pop/replace-top, soft clear and sticky error flags.
// Define LIFO_PEEK_EN to add the combinational 'top' peek port.
module lifo_stack_param #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count,
  output logic             ovf,
`ifdef LIFO_PEEK_EN
  output logic             udf,
  output logic [WIDTH-1:0] top
`else
  output logic             udf
`endif
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    sp;
  logic [AW-1:0]    top_idx;
  logic [AW:0]      count_nxt;
  logic [WIDTH-1:0] dout_nxt;
  logic             vld_nxt;
  logic             ovf_nxt;
  logic             udf_nxt;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;

  // When full, count[AW-1:0] wraps to 0, but sp is never used as a write address then.
  assign sp      = count[AW-1:0];
  assign top_idx = sp - AW'(1);
  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);

  always_comb begin
    count_nxt = count;
    dout_nxt  = dout;
    vld_nxt   = 1'b0;
    ovf_nxt   = ovf;
    udf_nxt   = udf;
    wr_en     = 1'b0;
    wr_addr   = sp;
    if (en) begin
      if (clr) begin
        count_nxt = '0;
        ovf_nxt   = 1'b0;
        udf_nxt   = 1'b0;
      end else if (push && pop) begin
        if (empty) begin
          // Nothing to pop: degrade to a plain push and flag the underflow.
          wr_en     = 1'b1;
          wr_addr   = sp;
          count_nxt = count + ONE_CNT;
          udf_nxt   = 1'b1;
        end else begin
          wr_en    = 1'b1;
          wr_addr  = top_idx;
          dout_nxt = mem[top_idx];
          vld_nxt  = 1'b1;
        end
      end else if (push) begin
        if (full) begin
          ovf_nxt = 1'b1;
        end else begin
          wr_en     = 1'b1;
          wr_addr   = sp;
          count_nxt = count + ONE_CNT;
        end
      end else if (pop) begin
        if (empty) begin
          udf_nxt = 1'b1;
        end else begin
          dout_nxt  = mem[top_idx];
          vld_nxt   = 1'b1;
          count_nxt = count - ONE_CNT;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count    <= '0;
      dout     <= '0;
      dout_vld <= 1'b0;
      ovf      <= 1'b0;
      udf      <= 1'b0;
    end else begin
      count    <= count_nxt;
      dout     <= dout_nxt;
      dout_vld <= vld_nxt;
      ovf      <= ovf_nxt;
      udf      <= udf_nxt;
    end
  end

  // Storage is deliberately not reset; rst only gates writes so a held reset aborts pushes.
  always_ff @(posedge clk) begin
    if (wr_en && rst) begin
      mem[wr_addr] <= din;
    end
  end

`ifdef LIFO_PEEK_EN
  assign top = empty ? '0 : mem[top_idx];
`endif

endmodule

// File: tb/tb_lifo_stack_param.sv
// Directed table-driven bench for lifo_stack_param (WIDTH=16, DEPTH=4).
// Checks 'top' only when built with LIFO_PEEK_EN.
module tb_lifo_stack_param;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic             clk;
  logic             rst;
  logic             en;
  logic             clr;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             dout_vld;
  logic             empty;
  logic             full;
  logic [AW:0]      count;
  logic             ovf;
  logic             udf;
`ifdef LIFO_PEEK_EN
  logic [WIDTH-1:0] top;
`endif

  lifo_stack_param #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .clr      (clr),
    .push     (push),
    .pop      (pop),
    .din      (din),
    .dout     (dout),
    .dout_vld (dout_vld),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .ovf      (ovf),
`ifdef LIFO_PEEK_EN
    .udf      (udf),
    .top      (top)
`else
    .udf      (udf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        en;
    logic        clr;
    logic        push;
    logic        pop;
    logic [15:0] din;
    logic [2:0]  e_count;
    logic [15:0] e_dout;
    logic        e_vld;
    logic        e_ovf;
    logic        e_udf;
    logic [15:0] e_top;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic add(input logic e, input logic c, input logic pu, input logic po,
                     input logic [15:0] d, input logic [2:0] ec, input logic [15:0] ed,
                     input logic ev, input logic eo, input logic eu, input logic [15:0] et);
    vec_t v;
    v.en = e; v.clr = c; v.push = pu; v.pop = po; v.din = d;
    v.e_count = ec; v.e_dout = ed; v.e_vld = ev; v.e_ovf = eo; v.e_udf = eu; v.e_top = et;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic check_state(input int idx, input logic [2:0] ec, input logic [15:0] ed,
                             input logic ev, input logic eo, input logic eu, input logic [15:0] et);
    check("count", idx, 32'(count), 32'(ec));
    check("dout", idx, 32'(dout), 32'(ed));
    check("dout_vld", idx, 32'(dout_vld), 32'(ev));
    check("empty", idx, 32'(empty), 32'(ec == 3'd0));
    check("full", idx, 32'(full), 32'(ec == 3'(DEPTH)));
    check("ovf", idx, 32'(ovf), 32'(eo));
    check("udf", idx, 32'(udf), 32'(eu));
`ifdef LIFO_PEEK_EN
    check("top", idx, 32'(top), 32'(et));
`else
    if (et === 16'hxxxx) n_fail++;
`endif
  endtask

  task automatic drive(input logic e, input logic c, input logic pu, input logic po, input logic [15:0] d);
    en = e; clr = c; push = pu; pop = po; din = d;
  endtask

  initial begin
    //   en clr push pop din       count dout     vld ovf udf top
    add(1, 0, 1, 0, 16'h1111, 3'd1, 16'h0000, 0, 0, 0, 16'h1111);
    add(1, 0, 1, 0, 16'h2222, 3'd2, 16'h0000, 0, 0, 0, 16'h2222);
    add(1, 0, 1, 0, 16'h3333, 3'd3, 16'h0000, 0, 0, 0, 16'h3333);
    add(1, 0, 1, 0, 16'h4444, 3'd4, 16'h0000, 0, 0, 0, 16'h4444);
    add(1, 0, 1, 0, 16'h5555, 3'd4, 16'h0000, 0, 1, 0, 16'h4444);
    add(1, 0, 0, 1, 16'h0000, 3'd3, 16'h4444, 1, 1, 0, 16'h3333);
    add(1, 0, 0, 1, 16'h0000, 3'd2, 16'h3333, 1, 1, 0, 16'h2222);
    add(1, 0, 0, 1, 16'h0000, 3'd1, 16'h2222, 1, 1, 0, 16'h1111);
    add(1, 0, 0, 1, 16'h0000, 3'd0, 16'h1111, 1, 1, 0, 16'h0000);
    add(1, 0, 0, 1, 16'h0000, 3'd0, 16'h1111, 0, 1, 1, 16'h0000);
    add(1, 1, 0, 0, 16'h0000, 3'd0, 16'h1111, 0, 0, 0, 16'h0000);
    add(1, 0, 0, 1, 16'h0000, 3'd0, 16'h1111, 0, 0, 1, 16'h0000);
    add(1, 0, 1, 1, 16'hABCD, 3'd1, 16'h1111, 0, 0, 1, 16'hABCD);
    add(1, 1, 0, 0, 16'h0000, 3'd0, 16'h1111, 0, 0, 0, 16'h0000);
    add(1, 0, 1, 0, 16'h0001, 3'd1, 16'h1111, 0, 0, 0, 16'h0001);
    add(1, 0, 1, 0, 16'h0002, 3'd2, 16'h1111, 0, 0, 0, 16'h0002);
    add(1, 0, 1, 1, 16'h00FF, 3'd2, 16'h0002, 1, 0, 0, 16'h00FF);
    add(1, 0, 0, 1, 16'h0000, 3'd1, 16'h00FF, 1, 0, 0, 16'h0001);
    for (int i = 0; i < 5; i++)
      add(0, 1, 1, 1, 16'h9999, 3'd1, 16'h00FF, 0, 0, 0, 16'h0001);
    add(1, 0, 0, 1, 16'h0000, 3'd0, 16'h0001, 1, 0, 0, 16'h0000);
    add(1, 0, 0, 1, 16'h0000, 3'd0, 16'h0001, 0, 0, 1, 16'h0000);
    add(1, 0, 1, 0, 16'h000A, 3'd1, 16'h0001, 0, 0, 1, 16'h000A);
    add(1, 0, 1, 0, 16'h000B, 3'd2, 16'h0001, 0, 0, 1, 16'h000B);
    add(1, 0, 1, 0, 16'h000C, 3'd3, 16'h0001, 0, 0, 1, 16'h000C);
    add(1, 0, 1, 0, 16'h000D, 3'd4, 16'h0001, 0, 0, 1, 16'h000D);
    add(1, 0, 1, 0, 16'h000E, 3'd4, 16'h0001, 0, 1, 1, 16'h000D);
    add(1, 0, 0, 1, 16'h0000, 3'd3, 16'h000D, 1, 1, 1, 16'h000C);
    add(1, 1, 1, 1, 16'h7777, 3'd0, 16'h000D, 0, 0, 0, 16'h0000);
    add(1, 0, 1, 0, 16'h0021, 3'd1, 16'h000D, 0, 0, 0, 16'h0021);
    add(1, 0, 1, 0, 16'h0022, 3'd2, 16'h000D, 0, 0, 0, 16'h0022);
    add(1, 0, 1, 0, 16'h0023, 3'd3, 16'h000D, 0, 0, 0, 16'h0023);
    add(1, 0, 1, 0, 16'h0024, 3'd4, 16'h000D, 0, 0, 0, 16'h0024);
    add(1, 0, 1, 1, 16'h0025, 3'd4, 16'h0024, 1, 0, 0, 16'h0025);
    add(1, 0, 0, 1, 16'h0000, 3'd3, 16'h0025, 1, 0, 0, 16'h0023);

    rst = 1'b0;
    drive(0, 0, 0, 0, 16'h0000);
    repeat (2) @(negedge clk);
    check_state(-1, 3'd0, 16'h0000, 0, 0, 0, 16'h0000);
    rst = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].clr, vecs[i].push, vecs[i].pop, vecs[i].din);
      @(negedge clk);
      check_state(i, vecs[i].e_count, vecs[i].e_dout, vecs[i].e_vld,
                  vecs[i].e_ovf, vecs[i].e_udf, vecs[i].e_top);
    end

    // Asynchronous reset between edges, with a push pending and dout non-zero.
    drive(1, 0, 1, 0, 16'h0BAD);
    #2 rst = 1'b0;
    #1 check_state(100, 3'd0, 16'h0000, 0, 0, 0, 16'h0000);
    @(negedge clk);
    check_state(101, 3'd0, 16'h0000, 0, 0, 0, 16'h0000);
    drive(0, 0, 0, 0, 16'h0000);
    rst = 1'b1;
    @(negedge clk);
    check_state(102, 3'd0, 16'h0000, 0, 0, 0, 16'h0000);
    drive(1, 0, 1, 0, 16'h0042);
    @(negedge clk);
    check_state(103, 3'd1, 16'h0000, 0, 0, 0, 16'h0042);
    drive(1, 0, 0, 1, 16'h0000);
    @(negedge clk);
    check_state(104, 3'd0, 16'h0042, 1, 0, 0, 16'h0000);
    drive(0, 0, 0, 0, 16'h0000);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
